// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - three-digit multiplexed seven-segment scanner for packed BCD
// Frame-aligned commit of loaded values, leading-zero blanking, active-low outputs.
module bcd_seg_scanner #(
  parameter int DIV      = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] bcd_in,
  input  logic        load,
  output logic [2:0]  an,
  output logic [6:0]  seg,
  output logic        upd
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pc_q, pc_d;
  logic [1:0]    di_q, di_d;
  logic [11:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [11:0]   disp_q, disp_d;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          upd_q, upd_d;

  logic          tick;
  logic          commit;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    case (n)
      4'd0:    dec7 = 7'h40;
      4'd1:    dec7 = 7'h79;
      4'd2:    dec7 = 7'h24;
      4'd3:    dec7 = 7'h30;
      4'd4:    dec7 = 7'h19;
      4'd5:    dec7 = 7'h12;
      4'd6:    dec7 = 7'h02;
      4'd7:    dec7 = 7'h78;
      4'd8:    dec7 = 7'h00;
      4'd9:    dec7 = 7'h10;
      default: dec7 = 7'h3F;
    endcase
  endfunction

  always_comb begin
    tick   = (pc_q == PW'(DIV - 1));
    pc_d   = tick ? '0 : pc_q + 1'b1;
    di_d   = di_q;
    if (tick) begin
      di_d = (di_q == 2'd2) ? 2'd0 : di_q + 2'd1;
    end

    // Commit reads the old pend, so a load landing on the boundary waits a frame.
    commit   = tick && (di_q == 2'd2) && pend_v_q;
    disp_d   = commit ? pend_q : disp_q;
    pend_d   = load ? bcd_in : pend_q;
    pend_v_d = load ? 1'b1 : (commit ? 1'b0 : pend_v_q);
    upd_d    = commit;

    nib   = disp_d[3:0];
    blank = 1'b0;
    case (di_d)
      2'd1: begin
        nib   = disp_d[7:4];
        blank = BLANK_LZ && (disp_d[11:8] == 4'd0) && (disp_d[7:4] == 4'd0);
      end
      2'd2: begin
        nib   = disp_d[11:8];
        blank = BLANK_LZ && (disp_d[11:8] == 4'd0);
      end
      default: begin
        nib   = disp_d[3:0];
        blank = 1'b0;
      end
    endcase

    an_d  = tick ? ~(3'b001 << di_d) : an_q;
    seg_d = tick ? (blank ? 7'h7F : dec7(nib)) : seg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      di_q     <= 2'd2;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disp_q   <= '0;
      an_q     <= 3'b111;
      seg_q    <= 7'h7F;
      upd_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      di_q     <= di_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      disp_q   <= disp_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      upd_q    <= upd_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign upd = upd_q;

endmodule
